// File: rtl/rhythm_pkg.sv
// Shared encodings, judgement window bounds and saturation limits for the rhythm game.
package rhythm_pkg;

  typedef enum logic [1:0] {
    GradeNone    = 2'd0,
    GradePerfect = 2'd1,
    GradeGood    = 2'd2,
    GradeMiss    = 2'd3
  } grade_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPlay   = 2'd1,
    StResult = 2'd2
  } judge_state_e;

  localparam logic [2:0]  PERF_LO   = 3'd2;
  localparam logic [2:0]  PERF_HI   = 3'd4;
  localparam logic [2:0]  GUARD     = 3'd6;

  localparam logic [7:0]  COMBO_MAX = 8'd255;
  localparam logic [15:0] SCORE_MAX = 16'hFFFF;
  localparam logic [9:0]  CNT_MAX   = 10'd1023;

  function automatic logic [9:0] sat_inc_cnt(input logic [9:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 10'd1;
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for a raw push button.
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/note_judge.sv
// Judges button presses against the note in the judge slot and keeps combo, score and
// per-grade statistics across a round (IDLE -> PLAY -> RESULT).
module note_judge
  import rhythm_pkg::*;
#(
  parameter int unsigned PERFECT_PTS = 3,
  parameter int unsigned GOOD_PTS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  song,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        yellow_button,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic        delete,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [15:0] score,
  output logic [9:0]  perfect_cnt,
  output logic [9:0]  good_cnt,
  output logic [9:0]  miss_cnt,
  output logic [1:0]  grade,
  output logic        grade_vld,
  output logic        result
);

  logic red_press, blue_press, yellow_press;

  button_sync_edge u_red (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (red_button),
    .press_o (red_press)
  );

  button_sync_edge u_blue (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (blue_button),
    .press_o (blue_press)
  );

  button_sync_edge u_yellow (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (yellow_button),
    .press_o (yellow_press)
  );

  judge_state_e state_q, state_d;
  logic         delete_q, delete_d;
  logic [7:0]   combo_q, combo_d;
  logic [7:0]   max_combo_q, max_combo_d;
  logic [15:0]  score_q, score_d;
  logic [9:0]   perfect_cnt_q, perfect_cnt_d;
  logic [9:0]   good_cnt_q, good_cnt_d;
  logic [9:0]   miss_cnt_q, miss_cnt_d;
  grade_e       grade_q, grade_d;
  logic         grade_vld_q, grade_vld_d;
  logic         result_q, result_d;
  logic [2:0]   offset_q, offset_d;
  logic         slot_q, slot_d;

  logic        judge_en, in_window, is_perfect;
  logic        hit, wrong_colour, exit_miss;
  logic [7:0]  combo_inc;
  logic [16:0] pts, score_sum;

  // The finish cycle is not judged, so a note still in the slot is never counted as missed.
  assign judge_en   = (state_q == StPlay) && !finish;
  assign in_window  = (offset != GUARD);
  assign is_perfect = (offset >= PERF_LO) && (offset <= PERF_HI);

  assign hit = judge_en && in_window &&
               ((red_press && note_R_judge) || (blue_press && note_B_judge));
  assign wrong_colour = judge_en && in_window && !hit &&
      ((red_press && !blue_press && note_B_judge && !note_R_judge) ||
       (blue_press && !red_press && note_R_judge && !note_B_judge));
  assign exit_miss = judge_en && (offset_q == GUARD) && (offset == 3'd0) && slot_q;

  assign combo_inc = (combo_q == COMBO_MAX) ? combo_q : combo_q + 8'd1;
  assign pts       = is_perfect ? 17'(PERFECT_PTS) : 17'(GOOD_PTS);
  assign score_sum = {1'b0, score_q} + pts;

  always_comb begin
    state_d       = state_q;
    delete_d      = 1'b0;
    grade_vld_d   = 1'b0;
    combo_d       = combo_q;
    max_combo_d   = max_combo_q;
    score_d       = score_q;
    perfect_cnt_d = perfect_cnt_q;
    good_cnt_d    = good_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    grade_d       = grade_q;
    offset_d      = offset;
    // A hit note is gone from the slot, so it cannot also trigger an exit miss.
    slot_d        = (note_R_judge || note_B_judge) && !hit;

    unique case (state_q)
      StIdle: begin
        if (song != 2'd0) begin
          state_d       = StPlay;
          combo_d       = '0;
          max_combo_d   = '0;
          score_d       = '0;
          perfect_cnt_d = '0;
          good_cnt_d    = '0;
          miss_cnt_d    = '0;
          grade_d       = GradeNone;
        end
      end
      StPlay: begin
        if (finish) begin
          state_d = StResult;
        end else if (hit) begin
          delete_d    = 1'b1;
          grade_vld_d = 1'b1;
          combo_d     = combo_inc;
          if (combo_inc > max_combo_q) max_combo_d = combo_inc;
          score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[15:0];
          if (is_perfect) begin
            grade_d       = GradePerfect;
            perfect_cnt_d = sat_inc_cnt(perfect_cnt_q);
          end else begin
            grade_d    = GradeGood;
            good_cnt_d = sat_inc_cnt(good_cnt_q);
          end
        end else if (wrong_colour || exit_miss) begin
          grade_vld_d = 1'b1;
          grade_d     = GradeMiss;
          combo_d     = '0;
          miss_cnt_d  = sat_inc_cnt(miss_cnt_q);
        end
      end
      StResult: begin
        if (yellow_press) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    result_d = (state_d == StResult);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      delete_q      <= 1'b0;
      combo_q       <= '0;
      max_combo_q   <= '0;
      score_q       <= '0;
      perfect_cnt_q <= '0;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      grade_q       <= GradeNone;
      grade_vld_q   <= 1'b0;
      result_q      <= 1'b0;
      offset_q      <= '0;
      slot_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      delete_q      <= delete_d;
      combo_q       <= combo_d;
      max_combo_q   <= max_combo_d;
      score_q       <= score_d;
      perfect_cnt_q <= perfect_cnt_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      grade_q       <= grade_d;
      grade_vld_q   <= grade_vld_d;
      result_q      <= result_d;
      offset_q      <= offset_d;
      slot_q        <= slot_d;
    end
  end

  assign delete      = delete_q;
  assign combo       = combo_q;
  assign max_combo   = max_combo_q;
  assign score       = score_q;
  assign perfect_cnt = perfect_cnt_q;
  assign good_cnt    = good_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign grade       = grade_q;
  assign grade_vld   = grade_vld_q;
  assign result      = result_q;

endmodule
